// File: rtl/nvme_irq_coalesce.sv
// Multi-vector NVMe-style interrupt coalescing controller: per-vector event
// counters and aggregation timers, served one at a time with round-robin fairness.
module nvme_irq_coalesce #(
    parameter  int unsigned NUM_VEC = 4,
    parameter  int unsigned CNT_W   = 8,
    parameter  int unsigned TIME_W  = 16,
    localparam int unsigned VEC_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_VEC-1:0] cq_event,
    input  logic [NUM_VEC-1:0] vec_mask,
    input  logic [CNT_W-1:0]   agg_thr,
    input  logic [TIME_W-1:0]  agg_time,
    output logic               irq_req,
    output logic [VEC_W-1:0]   irq_vec,
    input  logic               irq_ack,
    output logic [NUM_VEC-1:0] pend
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W:0]        count_q [NUM_VEC];
    logic [CNT_W:0]        count_d [NUM_VEC];
    logic [TIME_W-1:0]     timer_q [NUM_VEC];
    logic [TIME_W-1:0]     timer_d [NUM_VEC];
    logic [VEC_W-1:0]      rr_q, rr_d;
    logic [VEC_W-1:0]      vec_q, vec_d;
    logic [NUM_VEC-1:0]    pend_q, pend_d;

    logic [CNT_W:0]        thr;
    logic [NUM_VEC-1:0]    ready;
    logic [NUM_VEC-1:0]    eligible;
    logic [2*NUM_VEC-1:0]  elig_dbl;
    logic [2*NUM_VEC-1:0]  elig_rot;
    logic                  grant_valid;
    logic [VEC_W-1:0]      grant_idx;
    logic                  ack_hit;

    // Readiness uses registered count/timer but live threshold inputs.
    always_comb begin
        thr = {1'b0, agg_thr} + (CNT_W+1)'(1);
        for (int unsigned i = 0; i < NUM_VEC; i++) begin
            ready[i] = (count_q[i] >= thr) ||
                       ((agg_time != '0) && (timer_q[i] >= agg_time));
        end
        eligible = ready & ~vec_mask;
    end

    // Rotate so bit 0 corresponds to rr_q, then take the lowest set bit.
    always_comb begin
        int unsigned sum;
        sum         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        elig_dbl    = {eligible, eligible};
        elig_rot    = elig_dbl >> rr_q;
        for (int unsigned k = 0; k < NUM_VEC; k++) begin
            if (!grant_valid && elig_rot[k]) begin
                sum = 32'(rr_q) + k;
                if (sum >= NUM_VEC) begin
                    sum = sum - NUM_VEC;
                end
                grant_valid = 1'b1;
                grant_idx   = VEC_W'(sum);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        rr_d    = rr_q;
        ack_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = REQ;
                    vec_d   = grant_idx;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d = IDLE;
                    ack_hit = 1'b1;
                    rr_d    = (32'(vec_q) == NUM_VEC - 1) ? '0 : vec_q + VEC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_VEC; i++) begin
            count_d[i] = count_q[i];
            timer_d[i] = timer_q[i];
            if (ack_hit && (32'(vec_q) == i)) begin
                count_d[i] = cq_event[i] ? (CNT_W+1)'(1) : '0;
                timer_d[i] = '0;
            end else begin
                if (cq_event[i] && (count_q[i] != '1)) begin
                    count_d[i] = count_q[i] + (CNT_W+1)'(1);
                end
                if (count_q[i] == '0) begin
                    timer_d[i] = '0;
                end else if (timer_q[i] != '1) begin
                    timer_d[i] = timer_q[i] + TIME_W'(1);
                end
            end
            pend_d[i] = (count_d[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            rr_q    <= '0;
            pend_q  <= '0;
            for (int unsigned i = 0; i < NUM_VEC; i++) begin
                count_q[i] <= '0;
                timer_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            rr_q    <= rr_d;
            pend_q  <= pend_d;
            for (int unsigned i = 0; i < NUM_VEC; i++) begin
                count_q[i] <= count_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

    assign irq_req = (state_q == REQ);
    assign irq_vec = vec_q;
    assign pend    = pend_q;

endmodule

// File: tb/tb_nvme_irq_coalesce.sv
// Directed bench for nvme_irq_coalesce with a cycle-level behavioural model
// checked every cycle plus literal expectations at key points.
module tb_nvme_irq_coalesce;

    localparam int NV   = 4;
    localparam int CW   = 8;
    localparam int TW   = 16;
    localparam int CMAX = (1 << (CW + 1)) - 1;
    localparam int TMAX = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NV-1:0] cq_event;
    logic [NV-1:0] vec_mask;
    logic [CW-1:0] agg_thr;
    logic [TW-1:0] agg_time;
    logic          irq_req;
    logic [1:0]    irq_vec;
    logic          irq_ack;
    logic [NV-1:0] pend;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    nvme_irq_coalesce #(.NUM_VEC(NV), .CNT_W(CW), .TIME_W(TW)) dut (
        .clk(clk), .reset_n(reset_n), .cq_event(cq_event), .vec_mask(vec_mask),
        .agg_thr(agg_thr), .agg_time(agg_time), .irq_req(irq_req),
        .irq_vec(irq_vec), .irq_ack(irq_ack), .pend(pend)
    );

    always #5 clk = ~clk;

    // Model: counts/timers as plain integers, one outstanding grant, rotating start.
    int m_cnt [NV];
    int m_tmr [NV];
    int pc [NV];
    int pt [NV];
    bit m_req;
    int m_vec;
    int m_rr;

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NV; i++) begin
                m_cnt[i] = 0;
                m_tmr[i] = 0;
            end
            m_req = 0;
            m_vec = 0;
            m_rr  = 0;
        end else begin
            int acked;
            bit found;
            acked = -1;
            found = 0;
            for (int i = 0; i < NV; i++) begin
                pc[i] = m_cnt[i];
                pt[i] = m_tmr[i];
            end
            if (m_req) begin
                if (irq_ack) begin
                    acked = m_vec;
                    m_req = 0;
                    m_rr  = (m_vec + 1) % NV;
                end
            end else begin
                for (int k = 0; k < NV; k++) begin
                    int j;
                    j = (m_rr + k) % NV;
                    if (!found && !vec_mask[j] &&
                        ((pc[j] >= int'(agg_thr) + 1) ||
                         (agg_time != 0 && pt[j] >= int'(agg_time)))) begin
                        found = 1;
                        m_req = 1;
                        m_vec = j;
                    end
                end
            end
            for (int i = 0; i < NV; i++) begin
                if (i == acked) begin
                    m_cnt[i] = cq_event[i] ? 1 : 0;
                    m_tmr[i] = 0;
                end else begin
                    m_tmr[i] = (pc[i] != 0) ? ((pt[i] + 1 > TMAX) ? TMAX : pt[i] + 1) : 0;
                    m_cnt[i] = (pc[i] + int'(cq_event[i]) > CMAX) ? CMAX : pc[i] + int'(cq_event[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [NV-1:0] ep;
            for (int i = 0; i < NV; i++) ep[i] = (m_cnt[i] != 0);
            n_cmp++;
            if (irq_req !== m_req) begin
                n_bad++;
                $display("FAIL model_req t=%0t: got %b expected %b", $time, irq_req, m_req);
            end
            if (m_req) begin
                n_cmp++;
                if (32'(irq_vec) !== m_vec) begin
                    n_bad++;
                    $display("FAIL model_vec t=%0t: got %0d expected %0d", $time, irq_vec, m_vec);
                end
            end
            n_cmp++;
            if (pend !== ep) begin
                n_bad++;
                $display("FAIL model_pend t=%0t: got %b expected %b", $time, pend, ep);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic wait_req(input int maxc);
        bit ok;
        ok = 0;
        for (int c = 0; c < maxc && !ok; c++) begin
            if (irq_req === 1'b1) ok = 1;
            else cyc(1);
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL wait_req t=%0t: got irq_req=%b expected 1 within %0d cycles", $time, irq_req, maxc);
        end
    endtask

    task automatic ack_now();
        irq_ack = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
    endtask

    task automatic rr_seq(input string nm, input int first);
        cq_event = 4'b1111;
        cyc(1);
        cq_event = '0;
        for (int g = 0; g < NV; g++) begin
            wait_req(8);
            chk(nm, 32'(irq_vec), 32'((first + g) % NV));
            ack_now();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b0;
        cq_event = '0;
        vec_mask = '0;
        agg_thr  = '0;
        agg_time = '0;
        irq_ack  = 1'b0;
        cyc(3);
        chk_en = 1'b1;
        chk("reset_req", 32'(irq_req), 0);
        chk("reset_vec", 32'(irq_vec), 0);
        chk("reset_pend", 32'(pend), 0);
        reset_n = 1'b1;
        cyc(1);

        // basic request/ack
        cq_event = 4'b0100;
        cyc(1);
        cq_event = '0;
        chk("basic_pend_t1", 32'(pend), 32'h4);
        chk("basic_noreq_t1", 32'(irq_req), 0);
        cyc(1);
        chk("basic_req_t2", 32'(irq_req), 1);
        chk("basic_vec_t2", 32'(irq_vec), 2);
        chk("model_pin_basic", 32'(m_vec), 2);
        ack_now();
        chk("basic_req_after_ack", 32'(irq_req), 0);
        chk("basic_pend_after_ack", 32'(pend), 0);

        // threshold 3 (needs four events)
        agg_thr = 8'd3;
        repeat (3) begin
            cq_event = 4'b0001;
            cyc(1);
            cq_event = '0;
            cyc(1);
        end
        cyc(3);
        chk("thr_noreq_3ev", 32'(irq_req), 0);
        chk("thr_pend_3ev", 32'(pend), 32'h1);
        cq_event = 4'b0001;
        cyc(1);
        cq_event = '0;
        chk("thr_noreq_t1", 32'(irq_req), 0);
        cyc(1);
        chk("thr_req_t2", 32'(irq_req), 1);
        chk("thr_vec_t2", 32'(irq_vec), 0);
        ack_now();

        // time trigger at t+2+agg_time
        agg_thr  = 8'd255;
        agg_time = 16'd10;
        cq_event = 4'b0010;
        cyc(1);
        cq_event = '0;
        cyc(10);
        chk("time_noreq_t11", 32'(irq_req), 0);
        cyc(1);
        chk("time_req_t12", 32'(irq_req), 1);
        chk("time_vec_t12", 32'(irq_vec), 1);
        chk("model_pin_time", 32'(m_req), 1);
        ack_now();
        agg_time = '0;
        cq_event = 4'b0010;
        cyc(1);
        cq_event = '0;
        cyc(20);
        chk("time0_noreq", 32'(irq_req), 0);
        chk("time0_pend", 32'(pend), 32'h2);
        agg_thr = '0;
        cyc(1);
        chk("thr_change_req", 32'(irq_req), 1);
        chk("thr_change_vec", 32'(irq_vec), 1);
        ack_now();

        // round-robin from pointer 2, then from pointer 0
        rr_seq("rr_from2", 2);
        cq_event = 4'b1000;
        cyc(1);
        cq_event = '0;
        wait_req(8);
        chk("rr_prep_vec", 32'(irq_vec), 3);
        ack_now();
        chk("model_pin_rr", 32'(m_rr), 0);
        rr_seq("rr_from0", 0);

        // mask
        vec_mask = 4'b0010;
        cq_event = 4'b0010;
        cyc(1);
        cq_event = '0;
        cyc(4);
        chk("mask_noreq", 32'(irq_req), 0);
        chk("mask_pend", 32'(pend), 32'h2);
        vec_mask = '0;
        cyc(1);
        chk("unmask_req", 32'(irq_req), 1);
        chk("unmask_vec", 32'(irq_vec), 1);
        vec_mask = 4'b0010;
        cyc(3);
        chk("mask_hold_req", 32'(irq_req), 1);
        chk("mask_hold_vec", 32'(irq_vec), 1);
        ack_now();
        vec_mask = '0;
        chk("mask_ack_req", 32'(irq_req), 0);

        // counter saturation while masked
        vec_mask = 4'b1000;
        agg_thr  = 8'd255;
        cq_event = 4'b1000;
        cyc(520);
        cq_event = '0;
        chk("sat_pend", 32'(pend), 32'h8);
        chk("sat_noreq", 32'(irq_req), 0);
        chk("model_pin_sat", 32'(m_cnt[3]), 32'(CMAX));
        vec_mask = '0;
        cyc(1);
        chk("sat_req", 32'(irq_req), 1);
        chk("sat_vec", 32'(irq_vec), 3);
        ack_now();
        agg_thr = '0;

        // event on the granted vector in the ack cycle
        cq_event = 4'b0100;
        cyc(1);
        cq_event = '0;
        cyc(1);
        chk("evack_req", 32'(irq_req), 1);
        chk("evack_vec", 32'(irq_vec), 2);
        irq_ack  = 1'b1;
        cq_event = 4'b0100;
        cyc(1);
        irq_ack  = 1'b0;
        cq_event = '0;
        chk("evack_req_low", 32'(irq_req), 0);
        chk("evack_pend", 32'(pend), 32'h4);
        cyc(1);
        chk("evack_rereq", 32'(irq_req), 1);
        chk("evack_revec", 32'(irq_vec), 2);

        // reset during REQ
        reset_n = 1'b0;
        cyc(1);
        chk("rst_req", 32'(irq_req), 0);
        chk("rst_pend", 32'(pend), 0);
        chk("rst_vec", 32'(irq_vec), 0);
        reset_n = 1'b1;
        cyc(10);
        chk("rst_noreq_after", 32'(irq_req), 0);
        chk("rst_pend_after", 32'(pend), 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
